// File: rtl/sc_lane_shifter.sv
// Lane pattern bank: captures 14 initial lane patterns on LOAD, then rotates them
// (even lanes left, odd lanes right) every TICK_DIV >> SPEED cycles while enabled.
module sc_lane_shifter #(
    parameter int unsigned TICK_DIV = 12500000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic       SC_LANESHIFTER_CLOCK_50,
    input  logic       SC_LANESHIFTER_RESET_InLow,
    input  logic       SC_LANESHIFTER_LOAD_InHigh,
    input  logic       SC_LANESHIFTER_ENABLE_InHigh,
    input  logic [1:0] SC_LANESHIFTER_SPEED,
    input  logic [7:0] SC_LANESHIFTER_INIT_0,
    input  logic [7:0] SC_LANESHIFTER_INIT_1,
    input  logic [7:0] SC_LANESHIFTER_INIT_2,
    input  logic [7:0] SC_LANESHIFTER_INIT_3,
    input  logic [7:0] SC_LANESHIFTER_INIT_4,
    input  logic [7:0] SC_LANESHIFTER_INIT_5,
    input  logic [7:0] SC_LANESHIFTER_INIT_6,
    input  logic [7:0] SC_LANESHIFTER_INIT_7,
    input  logic [7:0] SC_LANESHIFTER_INIT_8,
    input  logic [7:0] SC_LANESHIFTER_INIT_9,
    input  logic [7:0] SC_LANESHIFTER_INIT_10,
    input  logic [7:0] SC_LANESHIFTER_INIT_11,
    input  logic [7:0] SC_LANESHIFTER_INIT_12,
    input  logic [7:0] SC_LANESHIFTER_INIT_13,
    output logic [7:0] SC_LANESHIFTER_ROW_0,
    output logic [7:0] SC_LANESHIFTER_ROW_1,
    output logic [7:0] SC_LANESHIFTER_ROW_2,
    output logic [7:0] SC_LANESHIFTER_ROW_3,
    output logic [7:0] SC_LANESHIFTER_ROW_4,
    output logic [7:0] SC_LANESHIFTER_ROW_5,
    output logic [7:0] SC_LANESHIFTER_ROW_6,
    output logic [7:0] SC_LANESHIFTER_ROW_7,
    output logic [7:0] SC_LANESHIFTER_ROW_8,
    output logic [7:0] SC_LANESHIFTER_ROW_9,
    output logic [7:0] SC_LANESHIFTER_ROW_10,
    output logic [7:0] SC_LANESHIFTER_ROW_11,
    output logic [7:0] SC_LANESHIFTER_ROW_12,
    output logic [7:0] SC_LANESHIFTER_ROW_13,
    output logic       SC_LANESHIFTER_TICK,
    output logic       SC_LANESHIFTER_RUNNING
);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period;
    logic             tick_q, tick_d;
    logic             load, enable, advance, wrap;
    logic [7:0]       init  [14];
    logic [7:0]       row_q [14];
    logic [7:0]       row_d [14];

    assign load   = SC_LANESHIFTER_LOAD_InHigh;
    assign enable = SC_LANESHIFTER_ENABLE_InHigh;

    assign init[0]  = SC_LANESHIFTER_INIT_0;
    assign init[1]  = SC_LANESHIFTER_INIT_1;
    assign init[2]  = SC_LANESHIFTER_INIT_2;
    assign init[3]  = SC_LANESHIFTER_INIT_3;
    assign init[4]  = SC_LANESHIFTER_INIT_4;
    assign init[5]  = SC_LANESHIFTER_INIT_5;
    assign init[6]  = SC_LANESHIFTER_INIT_6;
    assign init[7]  = SC_LANESHIFTER_INIT_7;
    assign init[8]  = SC_LANESHIFTER_INIT_8;
    assign init[9]  = SC_LANESHIFTER_INIT_9;
    assign init[10] = SC_LANESHIFTER_INIT_10;
    assign init[11] = SC_LANESHIFTER_INIT_11;
    assign init[12] = SC_LANESHIFTER_INIT_12;
    assign init[13] = SC_LANESHIFTER_INIT_13;

    assign SC_LANESHIFTER_ROW_0  = row_q[0];
    assign SC_LANESHIFTER_ROW_1  = row_q[1];
    assign SC_LANESHIFTER_ROW_2  = row_q[2];
    assign SC_LANESHIFTER_ROW_3  = row_q[3];
    assign SC_LANESHIFTER_ROW_4  = row_q[4];
    assign SC_LANESHIFTER_ROW_5  = row_q[5];
    assign SC_LANESHIFTER_ROW_6  = row_q[6];
    assign SC_LANESHIFTER_ROW_7  = row_q[7];
    assign SC_LANESHIFTER_ROW_8  = row_q[8];
    assign SC_LANESHIFTER_ROW_9  = row_q[9];
    assign SC_LANESHIFTER_ROW_10 = row_q[10];
    assign SC_LANESHIFTER_ROW_11 = row_q[11];
    assign SC_LANESHIFTER_ROW_12 = row_q[12];
    assign SC_LANESHIFTER_ROW_13 = row_q[13];

    assign SC_LANESHIFTER_TICK    = tick_q;
    assign SC_LANESHIFTER_RUNNING = (state_q == StRun);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        row_d   = row_q;
        period  = CNT_W'(TICK_DIV) >> SC_LANESHIFTER_SPEED;
        wrap    = (cnt_q >= period - CNT_W'(1));
        // The resume edge out of PAUSE counts, so each paused cycle costs exactly one cycle.
        advance = (state_q != StIdle) && enable && !load;

        if (load) begin
            row_d   = init;
            cnt_d   = '0;
            state_d = (state_q == StPause && !enable) ? StPause : StRun;
        end else begin
            case (state_q)
                StRun:   if (!enable) state_d = StPause;
                StPause: if (enable)  state_d = StRun;
                default: cnt_d = '0;
            endcase
        end

        if (advance) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                for (int i = 0; i < 14; i++) begin
                    if ((i % 2) == 0) row_d[i] = {row_q[i][6:0], row_q[i][7]};
                    else              row_d[i] = {row_q[i][0], row_q[i][7:1]};
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge SC_LANESHIFTER_CLOCK_50 or negedge SC_LANESHIFTER_RESET_InLow) begin
        if (!SC_LANESHIFTER_RESET_InLow) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            for (int i = 0; i < 14; i++) row_q[i] <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: tb/tb_sc_lane_shifter.sv
// Self-checking bench for sc_lane_shifter: directed scenarios plus random traffic
// compared against a behavioural lane model.
module tb_sc_lane_shifter;

    localparam int unsigned TickDiv = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [7:0] init [14];
    logic [7:0] row  [14];
    logic       tick, running;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model
    logic [7:0] m_row [14];
    int         m_cnt;
    bit         m_loaded, m_paused, m_tick;

    always #5 clk = ~clk;

    sc_lane_shifter #(.TICK_DIV(TickDiv), .CNT_W(4)) dut (
        .SC_LANESHIFTER_CLOCK_50     (clk),
        .SC_LANESHIFTER_RESET_InLow  (rst_n),
        .SC_LANESHIFTER_LOAD_InHigh  (load),
        .SC_LANESHIFTER_ENABLE_InHigh(en),
        .SC_LANESHIFTER_SPEED        (speed),
        .SC_LANESHIFTER_INIT_0 (init[0]),  .SC_LANESHIFTER_INIT_1 (init[1]),
        .SC_LANESHIFTER_INIT_2 (init[2]),  .SC_LANESHIFTER_INIT_3 (init[3]),
        .SC_LANESHIFTER_INIT_4 (init[4]),  .SC_LANESHIFTER_INIT_5 (init[5]),
        .SC_LANESHIFTER_INIT_6 (init[6]),  .SC_LANESHIFTER_INIT_7 (init[7]),
        .SC_LANESHIFTER_INIT_8 (init[8]),  .SC_LANESHIFTER_INIT_9 (init[9]),
        .SC_LANESHIFTER_INIT_10(init[10]), .SC_LANESHIFTER_INIT_11(init[11]),
        .SC_LANESHIFTER_INIT_12(init[12]), .SC_LANESHIFTER_INIT_13(init[13]),
        .SC_LANESHIFTER_ROW_0 (row[0]),  .SC_LANESHIFTER_ROW_1 (row[1]),
        .SC_LANESHIFTER_ROW_2 (row[2]),  .SC_LANESHIFTER_ROW_3 (row[3]),
        .SC_LANESHIFTER_ROW_4 (row[4]),  .SC_LANESHIFTER_ROW_5 (row[5]),
        .SC_LANESHIFTER_ROW_6 (row[6]),  .SC_LANESHIFTER_ROW_7 (row[7]),
        .SC_LANESHIFTER_ROW_8 (row[8]),  .SC_LANESHIFTER_ROW_9 (row[9]),
        .SC_LANESHIFTER_ROW_10(row[10]), .SC_LANESHIFTER_ROW_11(row[11]),
        .SC_LANESHIFTER_ROW_12(row[12]), .SC_LANESHIFTER_ROW_13(row[13]),
        .SC_LANESHIFTER_TICK   (tick),
        .SC_LANESHIFTER_RUNNING(running)
    );

    task automatic model_reset();
        for (int i = 0; i < 14; i++) m_row[i] = 8'h00;
        m_cnt = 0; m_loaded = 0; m_paused = 0; m_tick = 0;
    endtask

    // One clock edge of the lane model, using the inputs present at that edge.
    task automatic model_edge();
        int p;
        m_tick = 0;
        if (load) begin
            for (int i = 0; i < 14; i++) m_row[i] = init[i];
            m_cnt    = 0;
            m_paused = m_loaded && m_paused && !en;
            m_loaded = 1;
        end else if (m_loaded) begin
            if (en) begin
                m_paused = 0;
                p = TickDiv >> speed;
                if (m_cnt + 1 >= p) begin
                    m_cnt  = 0;
                    m_tick = 1;
                    for (int i = 0; i < 14; i++) begin
                        if (i % 2 == 0) m_row[i] = 8'((m_row[i] << 1) | (m_row[i] >> 7));
                        else            m_row[i] = 8'((m_row[i] >> 1) | (m_row[i] << 7));
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_paused = 1;
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 14; i++)
            check_val($sformatf("%s row%0d", tag, i), row[i], m_row[i]);
        check_val({tag, " tick"}, {7'd0, tick}, {7'd0, m_tick});
        check_val({tag, " running"}, {7'd0, running}, {7'd0, m_loaded && !m_paused});
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_init();
        for (int i = 0; i < 14; i++) init[i] = 8'($urandom);
    endtask

    initial begin
        rand_init();
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Idle: enable without load must do nothing.
        en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            rand_init();
            cycle("idle");
        end

        // Basic load and rotation at SPEED=0.
        rand_init();
        init[2] = 8'b1110_0000;
        init[3] = 8'b0000_0001;
        load = 1'b1;
        cycle("load");
        load = 1'b0;
        check_val("load row2", row[2], 8'b1110_0000);
        for (int j = 1; j <= 8; j++) begin
            cycle("speed0");
            check_val("speed0 tick timing", {7'd0, tick}, {7'd0, j == 8});
        end
        check_val("first tick row2", row[2], 8'b1100_0001);
        check_val("first tick row3", row[3], 8'b1000_0000);
        for (int j = 1; j <= 8; j++) begin
            cycle("speed0 second");
            check_val("second tick timing", {7'd0, tick}, {7'd0, j == 8});
        end

        // SPEED=3: tick every cycle.
        speed = 2'd3;
        init[10] = 8'b1100_1100;
        load = 1'b1;
        cycle("load s3");
        load = 1'b0;
        cycle("s3 a"); check_val("s3 row10 a", row[10], 8'b1001_1001);
        cycle("s3 b"); check_val("s3 row10 b", row[10], 8'b0011_0011);
        cycle("s3 c"); check_val("s3 row10 c", row[10], 8'b0110_0110);

        // Pause for 5 cycles after 3 counting cycles: tick 13 edges after load.
        speed = 2'd0;
        rand_init();
        load = 1'b1;
        cycle("load pause");
        load = 1'b0;
        for (int j = 1; j <= 13; j++) begin
            en = !(j >= 4 && j <= 8);
            cycle("pause");
            check_val("pause tick timing", {7'd0, tick}, {7'd0, j == 13});
        end
        en = 1'b1;

        // Load on the wrap edge beats the tick.
        rand_init();
        load = 1'b1;
        cycle("load wrap");
        load = 1'b0;
        for (int j = 0; j < 7; j++) cycle("pre-wrap");
        rand_init();
        load = 1'b1;
        cycle("reload at wrap");
        load = 1'b0;
        check_val("reload row5 unrotated", row[5], init[5]);
        check_val("reload tick", {7'd0, tick}, 8'd0);
        for (int j = 1; j <= 8; j++) begin
            cycle("after reload");
            check_val("reload tick timing", {7'd0, tick}, {7'd0, j == 8});
        end

        // Speed-up mid-count fires on the next edge.
        load = 1'b1;
        cycle("load speedup");
        load = 1'b0;
        for (int j = 0; j < 5; j++) cycle("count to 5");
        speed = 2'd3;
        cycle("speedup");
        check_val("speedup tick", {7'd0, tick}, 8'd1);
        speed = 2'd0;
        cycle("post speedup");

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async reset");
        #2;
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) cycle("post reset idle");

        // Random traffic.
        for (int j = 0; j < 400; j++) begin
            rand_init();
            load  = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 3) != 0);
            speed = 2'($urandom);
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
